regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised register file with reset, two write ports, write-to-read bypass and a per-register pending scoreboard. It replaces the single-write, negedge-written MIPS register file in the datapath and serves the decode stage. Two read ports are combinational. The scoreboard lets decode stall on registers whose value a load or multi-cycle unit still owes.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; the file holds 2**ADDR_W registers
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never pending
- BYPASS, 1, when 1 same-cycle write data is forwarded to read ports and busy flags

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- w_enable0  in  1  write port 0 enable
- w_addr0  in  ADDR_W  write port 0 address
- w_data0  in  DATA_W  write port 0 data
- w_enable1  in  1  write port 1 enable (higher priority)
- w_addr1  in  ADDR_W  write port 1 address
- w_data1  in  DATA_W  write port 1 data
- set_pend  in  1  mark register pend_addr as pending
- pend_addr  in  ADDR_W  register to mark pending
- r_addr1  in  ADDR_W  read port 1 address
- r_addr2  in  ADDR_W  read port 2 address
- r_data1  out  DATA_W  read port 1 data
- r_data2  out  DATA_W  read port 2 data
- busy1  out  1  register at r_addr1 is pending
- busy2  out  1  register at r_addr2 is pending

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits plus one pending bit per register.
- Write: on a rising clk, if w_enableN, rfile[w_addrN] <= w_dataN. When both ports target the same address, port 1's data is stored.
- Write-clears-pending: a write on either port to address A clears pend[A].
- Set-pending: on a rising clk, set_pend sets pend[pend_addr].
  - If the same cycle also writes pend_addr, the set wins: pend ends at 1 and the data is still stored.
  - Rationale: a new producer was issued.
- Read (combinational), priority highest first:
  - ZERO_REG and addr==0 gives 0.
  - BYPASS, w_enable1 and w_addr1==addr gives w_data1.
  - BYPASS, w_enable0 and w_addr0==addr gives w_data0.
  - Otherwise rfile[addr].
- Busy (combinational):
  - busyN = pend[r_addrN], forced 0 when ZERO_REG and r_addrN==0.
  - With BYPASS, busyN is also 0 when either write port writes r_addrN this cycle.
  - set_pend in the current cycle does not affect busy until the next edge.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - set_pend to address 0 is dropped.
  - Address 0 is never bypassed.
- ZERO_REG=0: register 0 is an ordinary register.
- BYPASS=0: read data and busy reflect state only. A value written this cycle is visible from the next cycle.

## Timing
- Reset (asynchronous, on rst rising, held while rst=1):
  - All registers are 0 and all pend bits are 0.
  - Therefore r_data1=r_data2=0 and busy1=busy2=0, except bypass paths, which remain active from write inputs during reset.
  - Writes and set_pend are ignored while rst=1.
- Reset deassertion mid-operation: the first rising edge with rst=0 performs normal updates. No partial write survives reset.
- Write latency:
  - 0 cycles to read ports with BYPASS=1.
  - 1 cycle (next edge) with BYPASS=0.
- Pending latency: set_pend at edge k makes busy=1 from edge k onward. A write at edge m>k makes busy=0 from edge m onward, or from the write cycle itself with BYPASS.
- Read paths and busy are purely combinational from addresses, write inputs and state.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst asynchronously between edges -> r_data1 for r_addr1=5 is 0 immediately, busy1=0; state stays 0 after release.
- Dual write collision: w_enable0=w_enable1=1, both addresses 7, data 0x11 / 0x22 -> same-cycle r_data1=0x22 (bypass); after edge r7=0x22. Then w0 to r3=0xAA, w1 to r4=0xBB -> both stored.
- Zero register: write 0x1234 to r0 and set_pend r0 -> r_data1=0 and busy1=0 in the same and next cycles.
- Scoreboard: set_pend r9 -> busy1=1 for r_addr1=9. Several idle cycles keep busy1=1. w_enable0 to r9 with 0x55 -> same cycle busy1=0 and r_data1=0x55. After edge busy1=0.
- Set/clear collision: set_pend r9 and w_enable1 r9=0x66 on the same edge -> after edge busy1=1 and r_data1=0x66.
- BYPASS=0, ZERO_REG=0 build: write r0=0x77 -> same cycle r_data1 shows old value 0; next cycle shows 0x77. Pending r2 stays busy during its write cycle.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: register file with two write ports, two combinational read
// ports, same-cycle write-to-read bypass and a per-register pending
// scoreboard for decode-stage stalls.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   w_enable0/w_addr0/w_data0      write port 0
//   w_enable1/w_addr1/w_data1      write port 1 (wins on address collision)
//   set_pend, pend_addr            mark a register as owed by a producer
//   r_addr1/r_data1/busy1          read port 1 data and pending flag
//   r_addr2/r_data2/busy2          read port 2 data and pending flag

// One register plus its pending bit. A set beats a clear on the same edge
// because it means a newer producer was just issued.
module regfile_sb_cell #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [DATA_W-1:0] wd,
   input  logic              set,
   output logic [DATA_W-1:0] q,
   output logic              pend
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q    <= '0;
         pend <= 1'b0;
      end else begin
         if (we) q <= wd;
         if (set)     pend <= 1'b1;
         else if (we) pend <= 1'b0;
      end
   end
endmodule

module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              w_enable0,
   input  logic [ADDR_W-1:0] w_addr0,
   input  logic [DATA_W-1:0] w_data0,
   input  logic              w_enable1,
   input  logic [ADDR_W-1:0] w_addr1,
   input  logic [DATA_W-1:0] w_data1,
   input  logic              set_pend,
   input  logic [ADDR_W-1:0] pend_addr,
   input  logic [ADDR_W-1:0] r_addr1,
   input  logic [ADDR_W-1:0] r_addr2,
   output logic [DATA_W-1:0] r_data1,
   output logic [DATA_W-1:0] r_data2,
   output logic              busy1,
   output logic              busy2
);
   localparam int NREG = 1 << ADDR_W;

   logic [NREG-1:0][DATA_W-1:0] regs;
   logic [NREG-1:0]             pend;

   // Storage: register 0 collapses to constants when it is hardwired zero.
   for (genvar i = 0; i < NREG; i++) begin : g_reg
      if (ZERO_REG != 0 && i == 0) begin : g_zero
         assign regs[i] = '0;
         assign pend[i] = 1'b0;
      end else begin : g_cell
         logic hit0, hit1;
         assign hit0 = w_enable0 && (w_addr0 == ADDR_W'(i));
         assign hit1 = w_enable1 && (w_addr1 == ADDR_W'(i));
         regfile_sb_cell #(.DATA_W(DATA_W)) u_cell (
            .clk  (clk),
            .rst  (rst),
            .we   (hit0 || hit1),
            .wd   (hit1 ? w_data1 : w_data0),
            .set  (set_pend && (pend_addr == ADDR_W'(i))),
            .q    (regs[i]),
            .pend (pend[i])
         );
      end
   end

   // Read ports share one description, indexed by port number.
   logic [1:0][ADDR_W-1:0] ra;
   logic [1:0][DATA_W-1:0] rd;
   logic [1:0]             bz;

   assign ra[0]   = r_addr1;
   assign ra[1]   = r_addr2;
   assign r_data1 = rd[0];
   assign r_data2 = rd[1];
   assign busy1   = bz[0];
   assign busy2   = bz[1];

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic is_zero, byp0, byp1;
      assign is_zero = (ZERO_REG != 0) && (ra[p] == '0);
      assign byp1    = (BYPASS != 0) && w_enable1 && (w_addr1 == ra[p]);
      assign byp0    = (BYPASS != 0) && w_enable0 && (w_addr0 == ra[p]);

      always_comb begin
         rd[p] = regs[ra[p]];
         if (is_zero)   rd[p] = '0;
         else if (byp1) rd[p] = w_data1;
         else if (byp0) rd[p] = w_data0;
      end

      // A same-cycle write delivers the owed value, so the reader need not stall.
      assign bz[p] = pend[ra[p]] && !is_zero && !byp0 && !byp1;
   end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: one default build (ZERO_REG=1,
// BYPASS=1) driven from a vector table, and a BYPASS=0/ZERO_REG=0 build
// checked with a short hand-written sequence. Expected outputs are queued
// when a vector is driven and compared when the outputs are sampled.
module tb_regfile_sb;
   logic        clk = 1'b0;
   logic        rst;
   logic        w_enable0, w_enable1, set_pend;
   logic [4:0]  w_addr0, w_addr1, pend_addr, r_addr1, r_addr2;
   logic [31:0] w_data0, w_data1;
   logic [31:0] a_d1, a_d2, b_d1, b_d2;
   logic        a_b1, a_b2, b_b1, b_b2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_sb dut_a (
      .clk(clk), .rst(rst),
      .w_enable0(w_enable0), .w_addr0(w_addr0), .w_data0(w_data0),
      .w_enable1(w_enable1), .w_addr1(w_addr1), .w_data1(w_data1),
      .set_pend(set_pend), .pend_addr(pend_addr),
      .r_addr1(r_addr1), .r_addr2(r_addr2),
      .r_data1(a_d1), .r_data2(a_d2), .busy1(a_b1), .busy2(a_b2)
   );

   regfile_sb #(.ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst),
      .w_enable0(w_enable0), .w_addr0(w_addr0), .w_data0(w_data0),
      .w_enable1(w_enable1), .w_addr1(w_addr1), .w_data1(w_data1),
      .set_pend(set_pend), .pend_addr(pend_addr),
      .r_addr1(r_addr1), .r_addr2(r_addr2),
      .r_data1(b_d1), .r_data2(b_d2), .busy1(b_b1), .busy2(b_b2)
   );

   typedef struct {
      logic        we0;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic        we1;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        sp;
      logic [4:0]  pa;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] d1;
      logic        b1;
      logic [31:0] d2;
      logic        b2;
      string       nm;
   } vec_t;

   typedef struct {
      logic [31:0] d1;
      logic        b1;
      logic [31:0] d2;
      logic        b2;
      bit          use_b;
      string       nm;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];

   function automatic vec_t mk(
      input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
      input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
      input logic sp, input logic [4:0] pa,
      input logic [4:0] ra1, input logic [4:0] ra2,
      input logic [31:0] d1, input logic b1,
      input logic [31:0] d2, input logic b2, input string nm);
      vec_t v;
      v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
      v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
      v.sp = sp; v.pa = pa; v.ra1 = ra1; v.ra2 = ra2;
      v.d1 = d1; v.b1 = b1; v.d2 = d2; v.b2 = b2; v.nm = nm;
      return v;
   endfunction

   // Vector with no writes and no set_pend; only read addresses and expectations.
   function automatic vec_t idle(
      input logic [4:0] ra1, input logic [4:0] ra2,
      input logic [31:0] d1, input logic b1,
      input logic [31:0] d2, input logic b2, input string nm);
      return mk(0, 0, 0, 0, 0, 0, 0, 0, ra1, ra2, d1, b1, d2, b2, nm);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_idle();
      w_enable0 = 0; w_addr0 = 0; w_data0 = 0;
      w_enable1 = 0; w_addr1 = 0; w_data1 = 0;
      set_pend  = 0; pend_addr = 0;
   endtask

   // Drive one vector just after a rising edge, queue its expectation, and
   // compare against the selected build on the following falling edge.
   task automatic apply(input vec_t v, input bit use_b);
      exp_t e;
      @(posedge clk); #1;
      w_enable0 = v.we0; w_addr0 = v.wa0; w_data0 = v.wd0;
      w_enable1 = v.we1; w_addr1 = v.wa1; w_data1 = v.wd1;
      set_pend = v.sp; pend_addr = v.pa;
      r_addr1 = v.ra1; r_addr2 = v.ra2;
      e.d1 = v.d1; e.b1 = v.b1; e.d2 = v.d2; e.b2 = v.b2;
      e.use_b = use_b; e.nm = v.nm;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s: scoreboard empty", v.nm);
      end else begin
         e = sb.pop_front();
         if (e.use_b) begin
            chk({e.nm, ".r_data1"}, b_d1, e.d1);
            chk({e.nm, ".busy1"},   {31'b0, b_b1}, {31'b0, e.b1});
            chk({e.nm, ".r_data2"}, b_d2, e.d2);
            chk({e.nm, ".busy2"},   {31'b0, b_b2}, {31'b0, e.b2});
         end else begin
            chk({e.nm, ".r_data1"}, a_d1, e.d1);
            chk({e.nm, ".busy1"},   {31'b0, a_b1}, {31'b0, e.b1});
            chk({e.nm, ".r_data2"}, a_d2, e.d2);
            chk({e.nm, ".busy2"},   {31'b0, a_b2}, {31'b0, e.b2});
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      rst = 1'b1;
      drive_idle();
      r_addr1 = 5; r_addr2 = 0;
      #2;
      chk("reset.a_d1", a_d1, 32'h0);
      chk("reset.a_b1", {31'b0, a_b1}, 32'h0);
      chk("reset.b_d2", b_d2, 32'h0);
      @(negedge clk); rst = 1'b0;

      // Write + set_pend r5 on one edge: set wins, data stored
      apply(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, 5, 5,
               32'hDEADBEEF, 0, 32'hDEADBEEF, 0, "w5_byp"), 0);
      apply(idle(5, 0, 32'hDEADBEEF, 1, 0, 0, "w5_stored"), 0);

      // Asynchronous reset between edges clears immediately
      #2 rst = 1'b1;
      #1;
      chk("async_rst.d1", a_d1, 32'h0);
      chk("async_rst.b1", {31'b0, a_b1}, 32'h0);
      // Writes and set_pend during reset are ignored
      @(posedge clk); #1;
      w_enable0 = 1; w_addr0 = 6; w_data0 = 32'h42; set_pend = 1; pend_addr = 6;
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk); rst = 1'b0;
      apply(idle(5, 6, 0, 0, 0, 0, "post_reset"), 0);

      // Main table, default build
      tbl.push_back(mk(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 0, 32'h22, 0, 0, 0, "collide"));
      tbl.push_back(idle(7, 7, 32'h22, 0, 32'h22, 0, "collide_st"));
      tbl.push_back(mk(1, 3, 32'hAA, 1, 4, 32'hBB, 0, 0, 3, 4, 32'hAA, 0, 32'hBB, 0, "dual"));
      tbl.push_back(idle(3, 4, 32'hAA, 0, 32'hBB, 0, "dual_st"));
      tbl.push_back(mk(1, 0, 32'h1234, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "zero_w"));
      tbl.push_back(idle(0, 0, 0, 0, 0, 0, "zero_st"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 9, 9, 7, 0, 0, 32'h22, 0, "setp9"));
      tbl.push_back(idle(9, 7, 0, 1, 32'h22, 0, "pend9_a"));
      tbl.push_back(idle(9, 0, 0, 1, 0, 0, "pend9_b"));
      tbl.push_back(idle(9, 0, 0, 1, 0, 0, "pend9_c"));
      tbl.push_back(mk(1, 9, 32'h55, 0, 0, 0, 0, 0, 9, 0, 32'h55, 0, 0, 0, "clr9_byp"));
      tbl.push_back(idle(9, 0, 32'h55, 0, 0, 0, "clr9_st"));
      tbl.push_back(mk(0, 0, 0, 1, 9, 32'h66, 1, 9, 9, 3, 32'h66, 0, 32'hAA, 0, "setclr9"));
      tbl.push_back(idle(9, 0, 32'h66, 1, 0, 0, "setclr9_st"));
      tbl.push_back(mk(1, 9, 32'h88, 1, 9, 32'h77, 0, 0, 4, 9, 32'hBB, 0, 32'h77, 0, "collide9"));
      tbl.push_back(idle(9, 4, 32'h77, 0, 32'hBB, 0, "collide9_st"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 12, 12, 12, 0, 0, 0, 0, "setp12"));
      tbl.push_back(mk(1, 13, 32'h5, 0, 0, 0, 0, 0, 12, 13, 0, 1, 32'h5, 0, "other_w"));
      tbl.push_back(idle(12, 13, 0, 1, 32'h5, 0, "other_st"));
      tbl.push_back(mk(1, 31, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 31, 12, 32'hFFFFFFFF, 0, 0, 1, "top_w"));
      tbl.push_back(idle(31, 31, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, "top_st"));
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 0);

      // No-bypass, ordinary-r0 build
      @(negedge clk); rst = 1'b1;
      drive_idle();
      @(negedge clk); rst = 1'b0;
      apply(mk(1, 0, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "nb_w0"), 1);
      apply(idle(0, 0, 32'h77, 0, 32'h77, 0, "nb_w0_st"), 1);
      apply(mk(0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 32'h77, 0, "nb_setp2"), 1);
      apply(mk(1, 2, 32'h99, 0, 0, 0, 0, 0, 2, 2, 0, 1, 0, 1, "nb_w2"), 1);
      apply(idle(2, 0, 32'h99, 0, 32'h77, 0, "nb_w2_st"), 1);
      apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h77, 0, 32'h77, 0, "nb_setp0"), 1);
      apply(idle(0, 2, 32'h77, 1, 32'h99, 0, "nb_pend0"), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
